wash_program_sequencer: RTL
===========================

// Module: wash_program_sequencer
// PURPOSE
//  Main controller of the washing machine. Runs the top-level machine state
//  (shutdown/begin/set/run/error/pause/finish) and sequences the 8 wash steps
//  on a 1 Hz tick. Drives the display/LED block directly: state[2:0],
//  data[9:0], and the three 6-bit display values outLeft, outMiddle, outRight.
// PARAMETERS
//  T_INWATER   3  ticks per in-water step (wash and rinse)
//  T_WASH      9  ticks for the wash step
//  T_OUTWATER  3  ticks per drain step (rinse and dry)
//  T_SPIN      3  ticks per spin step (rinse and dry)
//  T_RINSE     6  ticks for the rinse step
//  BEGIN_TICKS 2  ticks of lamp test in begin
//  FINISH_TICKS 5 ticks spent in finish before shutdown
// PORTS
//  cp         in   1  clock, rising edge
//  rst_n      in   1  reset; asynchronous, active-low
//  tick       in   1  1 Hz time base, one cp cycle wide
//  power_btn  in   1  power toggle, debounced one-cycle pulse
//  start_btn  in   1  start/pause, debounced one-cycle pulse
//  mode_btn   in   1  mode cycle, debounced one-cycle pulse
//  door_open  in   1  door switch level, 1 = open
//  state      out  3  0 shutdown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish
//  data       out 10  [9] set LED, [8] power LED, [7:0] one-hot active step
//  outLeft    out  6  total remaining ticks (0..33)
//  outMiddle  out  6  mode number (1..7)
//  outRight   out  6  remaining ticks of the current step
// BEHAVIOUR
//  - All outputs are registered. Async reset: state=0, data=0, outLeft=0,
//    outRight=0, outMiddle=7 (mode register=7).
//  - Steps 0..7 and their durations. Wash: 0 inWater, 1 W. Rinse: 2 outWater,
//    3 spin, 4 inWater, 5 R. Dry: 6 outWater, 7 spin.
//  - Step k drives data[7-k]=1. No step bit is set outside run, error or pause.
//  - Mode is a 3-bit mask: bit2 = wash, bit1 = rinse, bit0 = dry. Only
//    values 1..7 are legal. mode_btn in set steps 7->1->2->...->7.
//  - outLeft is the sum of the durations of all enabled steps that remain,
//    with the current step at its remaining count. Mode 7 gives 33.
//  - data[8]=1 in every state except shutdown. data[9]=1 only in set.
//  - In set: outLeft is recomputed one cycle after each mode change and
//    outRight=0.
//  - Transitions (evaluated each cp edge, first match wins):
//    1. power_btn in any state other than shutdown -> shutdown. This clears
//       data[9:0] and the timers; the mode register is kept.
//    2. shutdown: power_btn -> begin.
//    3. begin: after BEGIN_TICKS ticks -> set.
//    4. set: mode_btn cycles the mode. start_btn -> run, loading the first
//       enabled step and its duration into outRight.
//    5. run: door_open -> error. Otherwise start_btn -> pause. Otherwise, on
//       tick, outLeft decrements. If outRight>1, outRight decrements;
//       otherwise the block loads the next enabled step. If no enabled step
//       remains, state -> finish with data[7:0]=0, outLeft=0, outRight=0.
//    6. error: step and timers frozen. door_open deasserted -> pause.
//    7. pause: ticks are ignored. start_btn with door closed -> run, resuming
//       the same step and counts. start_btn with door open -> error.
//    8. finish: after FINISH_TICKS ticks -> shutdown.
//  - A tick in the same cycle as a state change is dropped, not counted.
//  - Tick counts for begin and finish restart on every entry to the state.
// TESTING
//  1. rst_n=0 mid-run -> state=0, data=0, outLeft=0, outRight=0, outMiddle=7,
//     all without a cp edge.
//  2. power_btn, then 2 ticks -> state 1 then 2; data=10'b11_0000_0000,
//     outMiddle=7, outLeft=33.
//  3. In set: 3x mode_btn -> outMiddle=3, outLeft=21. start_btn -> state=3,
//     data[7:0]=8'b0010_0000, outRight=3.
//  4. Mode 7, start, 33 ticks -> state 6 on the 33rd tick with data[7:0]=0.
//     After 5 more ticks -> state 0, data=0.
//  5. Run mode 7, 4 ticks in (step 1, outRight=8, outLeft=29), door_open=1 ->
//     state 4. Ticks leave counts unchanged. Door closed -> state 5.
//     start_btn -> state 3 with outRight=8, outLeft=29.
//  6. power_btn and start_btn in the same cycle in run -> state 0.
//     door_open and start_btn in the same cycle in run -> state 4.

Source files
------------

// File: rtl/wash_program_sequencer.sv
// Top-level washing machine controller: machine state, mode selection and the
// eight-step wash/rinse/dry sequence timed by a 1 Hz tick.
module wash_program_sequencer #(
    parameter int T_INWATER    = 3,
    parameter int T_WASH       = 9,
    parameter int T_OUTWATER   = 3,
    parameter int T_SPIN       = 3,
    parameter int T_RINSE      = 6,
    parameter int BEGIN_TICKS  = 2,
    parameter int FINISH_TICKS = 5
) (
    input  logic       cp,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       power_btn,
    input  logic       start_btn,
    input  logic       mode_btn,
    input  logic       door_open,
    output logic [2:0] state,
    output logic [9:0] data,
    output logic [5:0] outLeft,
    output logic [5:0] outMiddle,
    output logic [5:0] outRight
);

    typedef enum logic [2:0] {
        ST_SHUTDOWN = 3'd0,
        ST_BEGIN    = 3'd1,
        ST_SET      = 3'd2,
        ST_RUN      = 3'd3,
        ST_ERROR    = 3'd4,
        ST_PAUSE    = 3'd5,
        ST_FINISH   = 3'd6
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] step_q,  step_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [2:0] mode_q,  mode_d;
    logic [5:0] left_q,  left_d;
    logic [5:0] right_q, right_d;
    logic [9:0] data_q,  data_d;

    logic [3:0] first_step;
    logic [3:0] next_step;
    logic       step_on;

    function automatic logic [5:0] step_dur(input logic [2:0] k);
        case (k)
            3'd0, 3'd4: step_dur = 6'(T_INWATER);
            3'd1:       step_dur = 6'(T_WASH);
            3'd2, 3'd6: step_dur = 6'(T_OUTWATER);
            3'd3, 3'd7: step_dur = 6'(T_SPIN);
            default:    step_dur = 6'(T_RINSE);
        endcase
    endfunction

    // Steps 0-1 belong to wash (mode bit 2), 2-5 to rinse (bit 1), 6-7 to dry (bit 0).
    function automatic logic step_en(input logic [2:0] m, input logic [2:0] k);
        if (k <= 3'd1)      step_en = m[2];
        else if (k <= 3'd5) step_en = m[1];
        else                step_en = m[0];
    endfunction

    function automatic logic [5:0] total_ticks(input logic [2:0] m);
        total_ticks = '0;
        for (int k = 0; k < 8; k++) begin
            if (step_en(m, 3'(k))) total_ticks = total_ticks + step_dur(3'(k));
        end
    endfunction

    // Returns {found, index} of the lowest enabled step at or above 'from'.
    function automatic logic [3:0] find_step(input logic [2:0] m, input logic [3:0] from);
        find_step = '0;
        for (int k = 7; k >= 0; k--) begin
            if (4'(k) >= from && step_en(m, 3'(k))) find_step = {1'b1, 3'(k)};
        end
    endfunction

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        left_d     = left_q;
        right_d    = right_q;
        first_step = find_step(mode_q, 4'd0);
        next_step  = find_step(mode_q, {1'b0, step_q} + 4'd1);

        if (power_btn && state_q != ST_SHUTDOWN) begin
            state_d = ST_SHUTDOWN;
            step_d  = '0;
            cnt_d   = '0;
            left_d  = '0;
            right_d = '0;
        end else begin
            case (state_q)
                ST_SHUTDOWN: begin
                    if (power_btn) begin
                        state_d = ST_BEGIN;
                        cnt_d   = '0;
                    end
                end
                ST_BEGIN: begin
                    if (tick) begin
                        if (cnt_q == 3'(BEGIN_TICKS - 1)) begin
                            state_d = ST_SET;
                            cnt_d   = '0;
                            left_d  = total_ticks(mode_q);
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ST_SET: begin
                    // Tracking the registered mode makes outLeft follow a mode change one cycle later.
                    left_d  = total_ticks(mode_q);
                    right_d = '0;
                    if (start_btn) begin
                        state_d = ST_RUN;
                        step_d  = first_step[2:0];
                        right_d = step_dur(first_step[2:0]);
                    end else if (mode_btn) begin
                        mode_d = (mode_q == 3'd7) ? 3'd1 : mode_q + 3'd1;
                    end
                end
                ST_RUN: begin
                    if (door_open) begin
                        state_d = ST_ERROR;
                    end else if (start_btn) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        left_d = left_q - 6'd1;
                        if (right_q > 6'd1) begin
                            right_d = right_q - 6'd1;
                        end else if (next_step[3]) begin
                            step_d  = next_step[2:0];
                            right_d = step_dur(next_step[2:0]);
                        end else begin
                            state_d = ST_FINISH;
                            step_d  = '0;
                            cnt_d   = '0;
                            left_d  = '0;
                            right_d = '0;
                        end
                    end
                end
                ST_ERROR: begin
                    if (!door_open) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (start_btn) state_d = door_open ? ST_ERROR : ST_RUN;
                end
                ST_FINISH: begin
                    if (tick) begin
                        if (cnt_q == 3'(FINISH_TICKS - 1)) begin
                            state_d = ST_SHUTDOWN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = ST_SHUTDOWN;
            endcase
        end

        step_on = (state_d == ST_RUN) || (state_d == ST_ERROR) || (state_d == ST_PAUSE);
        data_d  = {state_d == ST_SET, state_d != ST_SHUTDOWN,
                   step_on ? (8'h80 >> step_d) : 8'h00};
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SHUTDOWN;
            step_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 3'd7;
            left_q  <= '0;
            right_q <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            left_q  <= left_d;
            right_q <= right_d;
            data_q  <= data_d;
        end
    end

    assign state     = state_q;
    assign data      = data_q;
    assign outLeft   = left_q;
    assign outMiddle = {3'b000, mode_q};
    assign outRight  = right_q;

endmodule
